conv_encoder_param: RTL and testbench
=====================================

Name: conv_encoder_param

Overview:
Parametrised rate-1/N feed-forward convolutional encoder, the successor to the fixed K=3, rate-1/2 Viterbi encoder. Constraint length, output count and generator polynomials are generic. The block frames input itself: it accepts FRAME_LEN info bits and then appends K-1 zero tail bits. Valid/ready handshakes on both sides let it sit between the bit source and the channel or Viterbi decoder model.

Parameters:
K, 3, constraint length (2..9); shift register holds K-1 past bits
N, 2, coded bits per info bit (rate 1/N), 2..4
G, {3'b101,3'b111}, packed generators, N*K bits; slice i = G[(i+1)*K-1 : i*K] drives code_out[i]
FRAME_LEN, 8, info bits per frame (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active high
st  in  1  frame start pulse; honoured only in IDLE
code_in  in  1  info bit
in_valid  in  1  code_in valid
in_ready  out  1  encoder accepts code_in this cycle
code_out  out  N  coded symbol
out_valid  out  1  code_out valid
out_ready  in  1  downstream accepts code_out
out_last  out  1  marks final tail symbol of frame
out_mask  out  N  per-bit keep mask (see Optional Feature)
busy  out  1  high in DATA or TAIL

Behaviour:
- Reset (async, rst=1): state=IDLE; sr=0; counter=0; code_out=0; out_valid=0; out_last=0; out_mask=all ones; in_ready=0; busy=0.
- Tap window: w = {b, sr[K-2:0]}. w[K-1]=current bit b, w[K-2]=most recent past bit. code_out[i] = XOR-reduce(w AND G_i).
- Shift: on each encoded bit, sr <= {b, sr[K-2:1]}.
- FSM: IDLE -> DATA on st=1. DATA -> TAIL after FRAME_LEN accepted bits. TAIL -> IDLE after K-1 tail symbols are emitted.
- IDLE: sr forced to 0.
- st is ignored in DATA and TAIL; no restart or abort.
- Advance condition: adv = !out_valid || out_ready.
- DATA: in_ready = adv. On in_valid && in_ready, encode code_in.
- TAIL: in_ready=0. Encode b=0 whenever adv=1; in_valid is ignored.
- Latency: an encoded symbol is registered into code_out with out_valid=1 on the clock edge that accepts it, i.e. one cycle later.
- Output hold: code_out, out_valid, out_mask and out_last stay stable while out_valid && !out_ready. out_valid clears after a handshake if no new symbol is produced.
- Throughput: one symbol per cycle under full flow.
- out_last=1 only with the K-1'th tail symbol. Frame length is FRAME_LEN+K-1 symbols.
- Counter: width $clog2(FRAME_LEN+K). Counts symbols in the frame and resets to 0 on IDLE entry.
- Back-to-back frames: st is honoured in IDLE on the cycle after out_last is registered. The pending last symbol may still drain concurrently.
- busy is registered; high from the cycle after st until the TAIL->IDLE transition.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro: CONV_ENC_PUNCT_EN.
- Defined, N=2: rate-2/3 puncturing with pattern [11;01] over the frame symbol index, which restarts at 0 each frame and continues through the tail. Even symbols: out_mask=2'b11. Odd symbols: out_mask=2'b01 (code_out[1] discarded downstream). code_out is still computed unpunctured.
- Defined, N!=2: out_mask stays all ones.
- Undefined: out_mask is constant all ones and no puncture logic is present.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs at reset values immediately; after release with st=0, busy=0 and out_valid=0.
- Basic frame (K=3, G=7,5 octal, FRAME_LEN=4, out_ready=1): st, then bits 1,0,1,1 -> code_out sequence 11,01,00,10,10,11; out_last only on the 6th; busy drops afterwards.
- Backpressure: same frame with out_ready low for 3 cycles after the 2nd symbol -> code_out holds 01 with out_valid=1, in_ready=0, and the sequence is unchanged.
- Input gaps and ignored st: in_valid toggling 1,0,1 plus st pulsed during DATA -> no duplicated or dropped bits, no restart; same 6-symbol output.
- Back-to-back frames: second st issued right after out_last -> second frame starts from sr=0 and yields an identical sequence for identical input.
- CONV_ENC_PUNCT_EN defined, basic frame -> out_mask 11,01,11,01,11,01, with code_out as in the basic frame; macro undefined -> out_mask=11 throughout.

Source files
------------

// File: rtl/conv_encoder_param.sv
// conv_encoder_param: rate-1/N feed-forward convolutional encoder with
// self-framing. It takes FRAME_LEN info bits, then appends K-1 zero tail bits.
// Valid/ready handshakes are used on the input side and on the output side.
// Optional build macro: CONV_ENC_PUNCT_EN. When it is defined and N==2,
// out_mask carries the rate-2/3 puncture pattern [11;01] over the symbol
// index within the frame.
module conv_encoder_param #(
   parameter int              K         = 3,
   parameter int              N         = 2,
   parameter logic [N*K-1:0]  G         = 6'b101_111,
   parameter int              FRAME_LEN = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          st,
   input  logic          code_in,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  code_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [N-1:0]  out_mask,
   output logic          busy
);

   // state | meaning
   // ------+-----------------------------------------------------------
   // IDLE  | waiting for st; shift register held at zero
   // DATA  | accepting and encoding FRAME_LEN info bits from code_in
   // TAIL  | flushing K-1 zero bits; the last one raises out_last

   localparam int CW = $clog2(FRAME_LEN + K);
   localparam logic [CW-1:0] DATA_LAST = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] TAIL_LAST = CW'(FRAME_LEN + K - 2);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_t;

   state_t          state, state_nx;
   logic [K-2:0]    sr;
   logic [CW-1:0]   cnt;
   logic            adv;
   logic            enc;
   logic            bit_in;
   logic [K-1:0]    win;
   logic [N-1:0]    sym;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic. Frame boundaries come from the symbol counter.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (st) state_nx = S_DATA;
         S_DATA:  if (enc && cnt == DATA_LAST) state_nx = S_TAIL;
         S_TAIL:  if (enc && cnt == TAIL_LAST) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output and control decode. A symbol is produced whenever the output
   // register is free or is being drained in this cycle.
   always_comb begin
      adv      = !out_valid || out_ready;
      in_ready = 1'b0;
      enc      = 1'b0;
      bit_in   = 1'b0;
      case (state)
         S_DATA: begin
            in_ready = adv;
            enc      = in_valid && adv;
            bit_in   = code_in;
         end
         S_TAIL:  enc = adv;
         default: ;
      endcase
   end

   // Tap window and generator parity. win[K-1] is the current bit.
   always_comb begin
      win = {bit_in, sr};
      sym = '0;
      for (int i = 0; i < N; i++) begin
         sym[i] = ^(win & G[i*K +: K]);
      end
   end

   // Shift register, symbol counter, output register and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr        <= '0;
         cnt       <= '0;
         code_out  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         busy <= (state_nx != S_IDLE);
         if (state == S_IDLE) begin
            sr  <= '0;
            cnt <= '0;
         end else if (enc) begin
            // win[K-1:1] is {b, sr[K-2:1]}; this form also works for K==2
            sr  <= win[K-1:1];
            cnt <= (state_nx == S_IDLE) ? '0 : cnt + CW'(1);
         end
         if (enc) begin
            code_out  <= sym;
            out_valid <= 1'b1;
            out_last  <= (state == S_TAIL) && (cnt == TAIL_LAST);
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

`ifdef CONV_ENC_PUNCT_EN
   generate
      if (N == 2) begin : g_punct
         // Even symbols keep both bits. Odd symbols drop code_out[1].
         always_ff @(posedge clk or posedge rst) begin
            if (rst)      out_mask <= '1;
            else if (enc) out_mask <= cnt[0] ? {{(N-1){1'b0}}, 1'b1} : {N{1'b1}};
         end
      end else begin : g_no_punct
         assign out_mask = '1;
      end
   endgenerate
`else
   assign out_mask = '1;
`endif

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed bench for conv_encoder_param: K=3, G=(7,5) octal, FRAME_LEN=4.
module tb_conv_encoder_param;

   localparam int K  = 3;
   localparam int N  = 2;
   localparam int FL = 4;
   localparam int NS = FL + K - 1;

   logic         clk = 1'b0;
   logic         rst, st, code_in, in_valid, in_ready;
   logic         out_valid, out_ready, out_last, busy;
   logic [N-1:0] code_out, out_mask;

   always #5 clk = ~clk;

   conv_encoder_param #(.K(K), .N(N), .G(6'b101_111), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .st(st), .code_in(code_in), .in_valid(in_valid),
      .in_ready(in_ready), .code_out(code_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_mask(out_mask), .busy(busy)
   );

   typedef struct {
      logic [3:0]  bits;   // MSB is the first bit sent
      logic [11:0] syms;   // MSB pair is the first symbol, {c1,c0}
      bit          stall;
      bit          gaps;
      bit          st_mid;
   } vec_t;

   vec_t vecs[6];

   int n_tests = 0;
   int n_fail  = 0;

   logic [N-1:0] cap_code[256];
   logic         cap_last[256];
   logic [N-1:0] cap_mask[256];
   int           cap_n = 0;

   // Record each symbol that will be handshaked on the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && cap_n < 256) begin
         cap_code[cap_n] = code_out;
         cap_last[cap_n] = out_last;
         cap_mask[cap_n] = out_mask;
         cap_n = cap_n + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for DUT", name);
   endtask

   function automatic logic [1:0] exp_mask(input int j);
`ifdef CONV_ENC_PUNCT_EN
      return (j % 2 == 1) ? 2'b01 : 2'b11;
`else
      return 2'b11;
`endif
   endfunction

   task automatic run_frame(input vec_t v);
      int base;
      int g;
      base = cap_n;
      st = 1'b1;
      @(posedge clk); #1 st = 1'b0;
      fork
         begin : feed
            for (int i = 0; i < FL; i++) begin
               int gw;
               code_in  = v.bits[FL-1-i];
               in_valid = 1'b1;
               if (v.st_mid && i == 1) st = 1'b1;
               gw = 0;
               @(negedge clk);
               while (!in_ready && gw < 50) begin
                  @(negedge clk);
                  gw++;
               end
               if (!in_ready) tmo("in_ready");
               @(posedge clk); #1;
               in_valid = 1'b0;
               st       = 1'b0;
               if (v.gaps) begin
                  @(posedge clk); #1;
               end
            end
         end
         begin : stall_branch
            if (v.stall) begin
               int gs;
               gs = 0;
               while (cap_n < base + 1 && gs < 50) begin
                  @(posedge clk);
                  gs++;
               end
               #1 out_ready = 1'b0;
               for (int c = 0; c < 3; c++) begin
                  @(negedge clk);
                  chk("stall_code", code_out, v.syms[9 -: 2]);
                  chk("stall_valid", out_valid, 1'b1);
                  chk("stall_in_ready", in_ready, 1'b0);
               end
               @(posedge clk); #1 out_ready = 1'b1;
            end
         end
      join
      g = 0;
      while (cap_n < base + NS && g < 100) begin
         @(negedge clk); #1;
         g++;
      end
      if (cap_n < base + NS) begin
         tmo("frame_symbols");
      end else begin
         for (int j = 0; j < NS; j++) begin
            chk($sformatf("sym%0d_code", j), cap_code[base+j], v.syms[11-2*j -: 2]);
            chk($sformatf("sym%0d_last", j), cap_last[base+j], (j == NS-1));
            chk($sformatf("sym%0d_mask", j), cap_mask[base+j], exp_mask(j));
         end
         chk("busy_after_frame", busy, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{bits: 4'b1011, syms: 12'b11_01_00_10_10_11, stall: 0, gaps: 0, st_mid: 0};
      vecs[1] = '{bits: 4'b1011, syms: 12'b11_01_00_10_10_11, stall: 1, gaps: 0, st_mid: 0};
      vecs[2] = '{bits: 4'b1011, syms: 12'b11_01_00_10_10_11, stall: 0, gaps: 1, st_mid: 1};
      vecs[3] = '{bits: 4'b1111, syms: 12'b11_10_01_01_10_11, stall: 0, gaps: 0, st_mid: 0};
      vecs[4] = '{bits: 4'b0100, syms: 12'b00_11_01_11_00_00, stall: 1, gaps: 0, st_mid: 0};
      vecs[5] = '{bits: 4'b0000, syms: 12'b00_00_00_00_00_00, stall: 0, gaps: 1, st_mid: 0};

      rst = 1'b1; st = 1'b0; code_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_code_out", code_out, 2'b00);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_mask", out_mask, 2'b11);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v]);
         repeat (2) @(posedge clk);
         #1;
      end

      // Back-to-back: the second st lands on the cycle right after out_last.
      run_frame(vecs[0]);
      run_frame(vecs[0]);
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a frame.
      st = 1'b1;
      @(posedge clk); #1 st = 1'b0;
      code_in = 1'b1; in_valid = 1'b1;
      @(posedge clk); @(posedge clk);
      #1 chk("pre_rst_out_valid", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_code_out", code_out, 2'b00);
      chk("mid_rst_out_last", out_last, 1'b0);
      chk("mid_rst_out_mask", out_mask, 2'b11);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      in_valid = 1'b0; code_in = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      run_frame(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
